// File: rtl/branch_predictor_if.sv
`default_nettype none
// ============================================================================
//  Module      : branch_predictor_if
//  Description : Fetch-side lookup and execute-side resolve/training bundle
//                shared between the pipeline (master) and the branch
//                predictor (slave).
//                Fetch : fetch_pc -> pred_taken, pred_target
//                Resolve: upd_valid, upd_pc, upd_is_cond, upd_taken,
//                         upd_target, upd_pred_taken, upd_pred_target
//                         -> mispredict, redirect_pc
//  Revision    : 1.0 - initial release
// ============================================================================
interface branch_predictor_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] fetch_pc;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
    logic            upd_valid;
    logic [XLEN-1:0] upd_pc;
    logic            upd_is_cond;
    logic            upd_taken;
    logic [XLEN-1:0] upd_target;
    logic            upd_pred_taken;
    logic [XLEN-1:0] upd_pred_target;
    logic            mispredict;
    logic [XLEN-1:0] redirect_pc;

    modport master (
        output fetch_pc, upd_valid, upd_pc, upd_is_cond, upd_taken,
               upd_target, upd_pred_taken, upd_pred_target,
        input  pred_taken, pred_target, mispredict, redirect_pc
    );

    modport slave (
        input  fetch_pc, upd_valid, upd_pc, upd_is_cond, upd_taken,
               upd_target, upd_pred_taken, upd_pred_target,
        output pred_taken, pred_target, mispredict, redirect_pc
    );
endinterface
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
//  Module      : branch_predictor
//  Description : Direct-mapped BTB plus 2-bit saturating BHT giving a
//                zero-latency next-PC prediction, and a mispredict detector
//                that trains both tables from resolved branches.
//  Ports       : clk    - core clock, all state on rising edge
//                rst_n  - synchronous active-low reset
//                bp     - branch_predictor_if.slave (fetch lookup + resolve)
//  Options     : BP_GSHARE_EN - XOR a non-speculative global history
//                register into the BHT index (BTB stays PC-indexed).
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 64,
    parameter int TAG_W   = 10
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    branch_predictor_if.slave bp
);
    localparam int IDX_W = $clog2(ENTRIES);

    // Table storage
    logic             r_valid   [ENTRIES];
    logic [TAG_W-1:0] r_tag     [ENTRIES];
    logic [XLEN-1:0]  r_target  [ENTRIES];
    logic             r_is_jump [ENTRIES];
    logic [1:0]       r_bht     [ENTRIES];

    // Fetch-side indexing
    logic [IDX_W-1:0] w_f_idx;
    logic [IDX_W-1:0] w_f_bidx;
    logic [TAG_W-1:0] w_f_tag;
    logic             w_f_hit;
    logic             w_pred_taken;

    // Resolve-side indexing
    logic [IDX_W-1:0] w_u_idx;
    logic [IDX_W-1:0] w_u_bidx;
    logic [TAG_W-1:0] w_u_tag;
    logic [1:0]       w_bht_next;
    logic [XLEN-1:0]  w_actual;
    logic [XLEN-1:0]  w_predicted;
    logic             w_train;

    // Only an index/tag slice of each PC is consumed.
    logic w_unused;
    assign w_unused = ^{bp.fetch_pc, bp.upd_pc};

    assign w_f_idx = bp.fetch_pc[IDX_W+1:2];
    assign w_f_tag = bp.fetch_pc[TAG_W+IDX_W+1:IDX_W+2];
    assign w_u_idx = bp.upd_pc[IDX_W+1:2];
    assign w_u_tag = bp.upd_pc[TAG_W+IDX_W+1:IDX_W+2];

`ifdef BP_GSHARE_EN
    logic [IDX_W-1:0] r_ghr;

    // History only advances on resolved conditional branches, so it never
    // needs repair after a flush.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ghr <= '0;
        end else if (bp.upd_valid && bp.upd_is_cond) begin
            r_ghr <= {r_ghr[IDX_W-2:0], bp.upd_taken};
        end
    end

    assign w_f_bidx = w_f_idx ^ r_ghr;
    assign w_u_bidx = w_u_idx ^ r_ghr;
`else
    assign w_f_bidx = w_f_idx;
    assign w_u_bidx = w_u_idx;
`endif

    // Lookup: reads pre-update contents, so a same-cycle write to the same
    // index becomes visible only on the following cycle.
    assign w_f_hit      = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
    assign w_pred_taken = w_f_hit && (r_is_jump[w_f_idx] || r_bht[w_f_bidx][1]);

    assign bp.pred_taken  = w_pred_taken;
    assign bp.pred_target = w_pred_taken ? r_target[w_f_idx] : bp.fetch_pc + XLEN'(4);

    // Resolve: compare full next-PC so a right-direction, wrong-target
    // prediction (e.g. JALR) still flushes.
    assign w_actual    = bp.upd_taken      ? bp.upd_target      : bp.upd_pc + XLEN'(4);
    assign w_predicted = bp.upd_pred_taken ? bp.upd_pred_target : bp.upd_pc + XLEN'(4);

    assign bp.mispredict  = bp.upd_valid && (w_actual != w_predicted);
    assign bp.redirect_pc = w_actual;

    assign w_train = rst_n && bp.upd_valid;

    always_comb begin
        w_bht_next = r_bht[w_u_bidx];
        if (bp.upd_taken) begin
            if (r_bht[w_u_bidx] != 2'b11) w_bht_next = r_bht[w_u_bidx] + 2'b01;
        end else begin
            if (r_bht[w_u_bidx] != 2'b00) w_bht_next = r_bht[w_u_bidx] - 2'b01;
        end
    end

    // Valid bits and counters carry reset state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
                r_bht[i]   <= 2'b01;
            end
        end else if (bp.upd_valid) begin
            if (bp.upd_taken) r_valid[w_u_idx] <= 1'b1;
            if (bp.upd_is_cond) r_bht[w_u_bidx] <= w_bht_next;
        end
    end

    // Entry payload is qualified by the valid bit, so it needs no reset.
    // A taken resolve always overwrites, evicting any aliasing entry; a
    // not-taken resolve leaves the entry in place for the BHT to decide.
    always_ff @(posedge clk) begin
        if (w_train && bp.upd_taken) begin
            r_tag[w_u_idx]     <= w_u_tag;
            r_target[w_u_idx]  <= bp.upd_target;
            r_is_jump[w_u_idx] <= !bp.upd_is_cond;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_predictor
//  Description : Directed self-checking bench for branch_predictor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predictor;
    localparam int XLEN    = 32;
    localparam int ENTRIES = 64;
    localparam int TAG_W   = 10;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    branch_predictor_if #(.XLEN(XLEN)) bif ();

    branch_predictor #(
        .XLEN    (XLEN),
        .ENTRIES (ENTRIES),
        .TAG_W   (TAG_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bp    (bif)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [XLEN-1:0] got,
                       input logic [XLEN-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input logic v, input logic [XLEN-1:0] pc, input logic cond,
                       input logic tk, input logic [XLEN-1:0] tgt,
                       input logic ptk, input logic [XLEN-1:0] ptgt);
        bif.upd_valid       = v;
        bif.upd_pc          = pc;
        bif.upd_is_cond     = cond;
        bif.upd_taken       = tk;
        bif.upd_target      = tgt;
        bif.upd_pred_taken  = ptk;
        bif.upd_pred_target = ptgt;
    endtask

    task automatic idle();
        bif.upd_valid = 1'b0;
    endtask

    task automatic train(input logic [XLEN-1:0] pc, input logic cond,
                         input logic tk, input logic [XLEN-1:0] tgt);
        upd(1'b1, pc, cond, tk, tgt, 1'b0, pc + 32'd4);
        tick();
        idle();
    endtask

    task automatic look(input string tag, input logic [XLEN-1:0] pc,
                        input logic exp_tk, input logic [XLEN-1:0] exp_tgt);
        bif.fetch_pc = pc;
        #1;
        chk({tag, "_tk"}, {31'd0, bif.pred_taken}, {31'd0, exp_tk});
        chk({tag, "_tgt"}, bif.pred_target, exp_tgt);
    endtask

    initial begin
        rst_n        = 1'b0;
        bif.fetch_pc = '0;
        // Update presented during reset must be ignored.
        upd(1'b1, 32'h100, 1'b1, 1'b1, 32'h80, 1'b0, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        idle();

        look("rst_a", 32'h100, 1'b0, 32'h104);
        look("rst_wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);

        upd(1'b0, 32'h100, 1'b1, 1'b1, 32'h80, 1'b0, 32'h0);
        #1;
        chk("idle_mp", {31'd0, bif.mispredict}, 32'd0);

        // Not-taken JAL-class resolve predicted not-taken: correct, no training.
        upd(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h1234, 1'b0, 32'h0);
        #1;
        chk("nt_ok_mp", {31'd0, bif.mispredict}, 32'd0);
        chk("nt_ok_redir", bif.redirect_pc, 32'h0);

        // First taken branch: mispredict, same-cycle lookup still sees old state.
        bif.fetch_pc = 32'h100;
        upd(1'b1, 32'h100, 1'b1, 1'b1, 32'h80, 1'b0, 32'h104);
        #1;
        chk("first_mp", {31'd0, bif.mispredict}, 32'd1);
        chk("first_redir", bif.redirect_pc, 32'h80);
        chk("first_same_cyc", {31'd0, bif.pred_taken}, 32'd0);
        tick();
        idle();

`ifndef BP_GSHARE_EN
        look("first_next", 32'h100, 1'b1, 32'h80);

        // Counter walk at 0x208 (idx 2), starting at 01.
        train(32'h208, 1'b1, 1'b1, 32'h600);                 // 10
        look("ctr_10", 32'h208, 1'b1, 32'h600);
        train(32'h208, 1'b1, 1'b1, 32'h600);                 // 11
        train(32'h208, 1'b1, 1'b1, 32'h600);                 // 11 saturated
        upd(1'b1, 32'h208, 1'b1, 1'b0, 32'h600, 1'b1, 32'h600);
        #1;
        chk("nt_mp", {31'd0, bif.mispredict}, 32'd1);
        chk("nt_redir", bif.redirect_pc, 32'h20C);
        tick();
        idle();                                              // 10
        look("ctr_sat_hi", 32'h208, 1'b1, 32'h600);
        train(32'h208, 1'b1, 1'b0, 32'h0);                   // 01
        look("ctr_01", 32'h208, 1'b0, 32'h20C);
        train(32'h208, 1'b1, 1'b0, 32'h0);                   // 00
        train(32'h208, 1'b1, 1'b0, 32'h0);                   // 00 saturated
        train(32'h208, 1'b1, 1'b1, 32'h600);                 // 01
        look("ctr_sat_lo", 32'h208, 1'b0, 32'h20C);
        train(32'h208, 1'b1, 1'b1, 32'h600);                 // 10
        look("ctr_back", 32'h208, 1'b1, 32'h600);

        // JALR at 0x30C (idx 3, BHT still 01).
        upd(1'b1, 32'h30C, 1'b0, 1'b1, 32'h400, 1'b0, 32'h310);
        #1;
        chk("jalr1_mp", {31'd0, bif.mispredict}, 32'd1);
        chk("jalr1_redir", bif.redirect_pc, 32'h400);
        tick();
        idle();
        look("jalr1", 32'h30C, 1'b1, 32'h400);
        upd(1'b1, 32'h30C, 1'b0, 1'b1, 32'h500, 1'b1, 32'h400);
        #1;
        chk("jalr2_mp", {31'd0, bif.mispredict}, 32'd1);
        chk("jalr2_redir", bif.redirect_pc, 32'h500);
        tick();
        idle();
        look("jalr2", 32'h30C, 1'b1, 32'h500);
        upd(1'b1, 32'h30C, 1'b0, 1'b1, 32'h500, 1'b1, 32'h500);
        #1;
        chk("jalr3_mp", {31'd0, bif.mispredict}, 32'd0);
        tick();
        idle();
        // Jumps left BHT[3] at 01: one taken then one not-taken returns to 01.
        train(32'h30C, 1'b1, 1'b1, 32'h500);
        look("jbht_t", 32'h30C, 1'b1, 32'h500);
        train(32'h30C, 1'b1, 1'b0, 32'h0);
        look("jbht_nt", 32'h30C, 1'b0, 32'h310);

        // Aliasing: 0x0 and 0x0 + 4*ENTRIES share idx 0.
        train(32'h0, 1'b1, 1'b1, 32'h40);
        look("alias_a", 32'h0, 1'b1, 32'h40);
        train(32'h0 + 32'(4 * ENTRIES), 1'b1, 1'b1, 32'h80);
        look("alias_evict", 32'h0, 1'b0, 32'h4);
        look("alias_b", 32'h0 + 32'(4 * ENTRIES), 1'b1, 32'h80);
`else
        // History now 1: lookup of 0x100 uses counter 1 (still 01).
        look("gs_hist1", 32'h100, 1'b0, 32'h104);
        // Six not-taken branches elsewhere shift history back to 0 without
        // touching counters 0 or 1.
        for (int i = 0; i < 6; i++) train(32'h1F0, 1'b1, 1'b0, 32'h0);
        look("gs_hist0", 32'h100, 1'b1, 32'h80);
`endif

        // Mid-run reset wipes all training.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        look("mrst_100", 32'h100, 1'b0, 32'h104);
        look("mrst_208", 32'h208, 1'b0, 32'h20C);
        look("mrst_30c", 32'h30C, 1'b0, 32'h310);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Dynamic branch predictor and mispredict detector, parked beside fetch, fed back from execute.
- Fetch side: a direct-mapped BTB plus a 2-bit BHT give a next-PC prediction in the same cycle.
- Execute side: consumes the resolved branch_taken/branch_target for each control-flow instruction, compares it with the prediction that travelled down the pipe, raises mispredict/redirect_pc and trains the tables.

Parameters:
- XLEN, 32, data/address width.
- ENTRIES, 64, BTB and BHT entry count; power of two, >= 4.
- TAG_W, 10, BTB tag width taken from PC bits above the index.

Ports:
- clk  input  1  core clock, all state on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- fetch_pc  input  XLEN  PC being fetched this cycle.
- pred_taken  output  1  predict redirect for fetch_pc.
- pred_target  output  XLEN  predicted target; equals fetch_pc+4 when pred_taken=0.
- upd_valid  input  1  resolved control-flow instruction present in EX this cycle.
- upd_pc  input  XLEN  PC of the resolved instruction.
- upd_is_cond  input  1  conditional branch (OP_BRANCH); 0 means JAL/JALR.
- upd_taken  input  1  resolved branch_taken.
- upd_target  input  XLEN  resolved branch_target.
- upd_pred_taken  input  1  pred_taken carried down the pipe for this instruction.
- upd_pred_target  input  XLEN  pred_target carried down the pipe.
- mispredict  output  1  flush younger instructions and redirect fetch.
- redirect_pc  output  XLEN  correct next PC.

Behaviour:
- Indexing:
  - idx = pc[IDX_W+1:2], where IDX_W = $clog2(ENTRIES).
  - tag = pc[TAG_W+IDX_W+1:IDX_W+2].
  - pc[1:0] is ignored.
- BTB entry: valid, tag, target[XLEN], is_jump.
- BHT: ENTRIES 2-bit saturating counters.
  - 00 = strong NT, 01 = weak NT, 10 = weak T, 11 = strong T.
- Lookup (combinational, zero latency):
  - hit = valid && tag match at idx.
  - pred_taken = hit && (is_jump || bht[bidx][1]).
  - pred_target = pred_taken ? target : fetch_pc+4.
- Resolve (combinational):
  - actual = upd_taken ? upd_target : upd_pc+4.
  - predicted = upd_pred_taken ? upd_pred_target : upd_pc+4.
  - mispredict = upd_valid && (actual != predicted).
  - redirect_pc = actual.
  - A correct-direction but wrong-target prediction (e.g. JALR) is a mispredict.
- Training at clock edge when upd_valid=1:
  - upd_is_cond=1: bht[bidx] increments if taken, decrements if not, saturating at 11/00.
  - upd_taken=1: BTB[idx] written with valid=1, new tag, upd_target, is_jump=!upd_is_cond. This replaces any aliasing entry.
  - upd_taken=0 with tag hit on a cond entry: BTB entry is kept; only the BHT learns.
  - JAL/JALR do not touch the BHT.
- Reset (rst_n=0 at edge):
  - All BTB valid bits cleared.
  - All BHT counters set to 01; GHR (if present) set to 0.
  - upd_valid is ignored while rst_n=0.
  - Holds mid-stream: entries trained before reset are gone afterwards.
- Output values:
  - After reset: pred_taken=0 and pred_target=fetch_pc+4 for any fetch_pc.
  - mispredict and redirect_pc are purely combinational from the upd_* inputs.
  - mispredict=0 whenever upd_valid=0.
- Simultaneous lookup and update to the same idx: lookup returns pre-update contents; new contents are visible from the next cycle.
- Arithmetic: pc+4 wraps modulo 2^XLEN (0xFFFFFFFC+4 = 0).
- Targets are stored verbatim; no alignment is applied here.

Optional Feature:
- BP_GSHARE_EN defined:
  - Adds GHR of IDX_W bits, reset 0.
  - BHT index bidx = idx XOR GHR.
  - On each upd_valid && upd_is_cond, GHR <= {GHR[IDX_W-2:0], upd_taken}.
  - The GHR is non-speculative, updated only at resolve.
  - The BTB stays PC-indexed.
- Undefined: no GHR; bidx = idx.

Test Plan:
- Reset then fetch_pc=0x100 -> pred_taken=0, pred_target=0x104. Then upd_valid, upd_pc=0x100, cond, taken, target=0x80, pred_taken=0 -> mispredict=1, redirect_pc=0x80.
- Next cycle fetch_pc=0x100 -> pred_taken=1, pred_target=0x80.
- Train a cond branch at 0x200 taken 3x (counter 01→10→11→11), then not-taken once -> counter 10, still pred_taken=1. Not-taken again -> counter 01, pred_taken=0.
- JALR at 0x300: resolved target 0x400, then 0x500 with upd_pred_target=0x400 -> mispredict=1, redirect_pc=0x500, BTB target becomes 0x500.
- Aliasing: train 0x0 taken→0x40, then 0x0+4*ENTRIES taken→0x80 -> fetch 0x0 misses (pred_target=0x4), fetch of the aliased PC predicts 0x80.
- Mid-run rst_n=0 for one cycle -> all previously trained PCs predict not-taken. With BP_GSHARE_EN: the same PC with opposite histories (after T vs. NT) trains distinct counters.
